// File: rtl/nbody_pkg.sv
// Shared n-body types: body count, position word width and the packed position record.
package nbody_pkg;

  localparam int N_BODIES = 256;
  localparam int WORD_W   = 16;

  typedef struct packed {
    logic [WORD_W-1:0] x;
    logic [WORD_W-1:0] y;
  } pos_t;

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } buf_state_t;

endpackage

// File: rtl/in_buffer_if.sv
// Stream-in and read-out signal bundle of the position input buffer.
interface in_buffer_if
  import nbody_pkg::*;
#(
  parameter int IDX_BITS = $clog2(N_BODIES)
);

  logic                CLEAR;
  logic [WORD_W-1:0]   DATA_IN;
  logic                D_VALID;
  logic                D_READY;
  logic                FRAME_VALID;
  logic                RD_EN;
  logic [IDX_BITS-1:0] RD_IDX;
  logic [WORD_W-1:0]   POS_X;
  logic [WORD_W-1:0]   POS_Y;
  logic                RD_VALID;

  modport master (
    output CLEAR, DATA_IN, D_VALID, RD_EN, RD_IDX,
    input  D_READY, FRAME_VALID, POS_X, POS_Y, RD_VALID
  );

  modport slave (
    input  CLEAR, DATA_IN, D_VALID, RD_EN, RD_IDX,
    output D_READY, FRAME_VALID, POS_X, POS_Y, RD_VALID
  );

endinterface

// File: rtl/pos_ram.sv
// Position storage: N x {x,y}, one synchronous write port, one registered read port.
module pos_ram
  import nbody_pkg::*;
#(
  parameter int N        = N_BODIES,
  parameter int IDX_BITS = $clog2(N)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_we,
  input  logic [IDX_BITS-1:0] i_waddr,
  input  pos_t                i_wdata,
  input  logic                i_re,
  input  logic [IDX_BITS-1:0] i_raddr,
  output pos_t                o_rdata
);

  pos_t r_mem [N];
  pos_t r_rdata_p1;

  // Write port: whole {x,y} entry written at once so readers never see half an update.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read port output register (stage p1); holds its value when no read is enabled.
  always_ff @(posedge i_clk) begin
    if (i_rst)     r_rdata_p1 <= '0;
    else if (i_re) r_rdata_p1 <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata_p1;

endmodule

// File: rtl/in_buffer.sv
// Input frame buffer: collects an X/Y word stream into N body positions and serves indexed reads.
module in_buffer
  import nbody_pkg::*;
#(
  parameter int N        = N_BODIES,
  parameter int IDX_BITS = $clog2(N)
) (
  input  logic        CLK_IN,
  input  logic        RESET_IN,
  in_buffer_if.slave  bus
);

  buf_state_t          r_state, w_state_nxt;
  logic [IDX_BITS-1:0] r_wr_idx, w_wr_idx_nxt;
  logic                r_phase, w_phase_nxt;
  logic [WORD_W-1:0]   r_hold_x;
  logic                w_accept;
  logic                w_wr_en;
  logic                w_rd_en;
  logic                r_rd_vld_p1;
  pos_t                w_wr_data;
  pos_t                w_rd_data;

  assign w_accept  = bus.D_VALID && (r_state == LOAD);
  assign w_rd_en   = bus.RD_EN && (r_state == FULL);
  assign w_wr_data = '{x: r_hold_x, y: bus.DATA_IN};

  // Next-state logic: CLEAR overrides any accept; a Y word commits the pair and advances the index.
  always_comb begin
    w_state_nxt  = r_state;
    w_wr_idx_nxt = r_wr_idx;
    w_phase_nxt  = r_phase;
    w_wr_en      = 1'b0;
    if (bus.CLEAR) begin
      w_state_nxt  = LOAD;
      w_wr_idx_nxt = '0;
      w_phase_nxt  = 1'b0;
    end else if (w_accept) begin
      if (!r_phase) begin
        w_phase_nxt = 1'b1;
      end else begin
        w_wr_en     = 1'b1;
        w_phase_nxt = 1'b0;
        if (r_wr_idx == IDX_BITS'(N - 1)) begin
          w_state_nxt  = FULL;
          w_wr_idx_nxt = '0;
        end else begin
          w_wr_idx_nxt = r_wr_idx + 1'b1;
        end
      end
    end
  end

  // State, write index and phase registers.
  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      r_state  <= LOAD;
      r_wr_idx <= '0;
      r_phase  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_wr_idx <= w_wr_idx_nxt;
      r_phase  <= w_phase_nxt;
    end
  end

  // Holding register for the X half; a word arriving with CLEAR is dropped.
  always_ff @(posedge CLK_IN) begin
    if (RESET_IN)                                r_hold_x <= '0;
    else if (w_accept && !r_phase && !bus.CLEAR) r_hold_x <= bus.DATA_IN;
  end

  // Read-valid travels with the RAM output register (stage p1).
  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) r_rd_vld_p1 <= 1'b0;
    else          r_rd_vld_p1 <= w_rd_en;
  end

  pos_ram #(
    .N        (N),
    .IDX_BITS (IDX_BITS)
  ) u_pos_ram (
    .i_clk   (CLK_IN),
    .i_rst   (RESET_IN),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_idx),
    .i_wdata (w_wr_data),
    .i_re    (w_rd_en),
    .i_raddr (bus.RD_IDX),
    .o_rdata (w_rd_data)
  );

  assign bus.D_READY     = (r_state == LOAD);
  assign bus.FRAME_VALID = (r_state == FULL);
  assign bus.RD_VALID    = r_rd_vld_p1;
  assign bus.POS_X       = w_rd_data.x;
  assign bus.POS_Y       = w_rd_data.y;

endmodule
